rf_wb_sched: RTL and testbench

RF_WB_SCHED -- requirements
Module: rf_wb_sched

---
 rtl/rf_wb_sched_pkg.sv | 16 +
 rtl/rf_wb_sched_rr_arbiter.sv | 35 +++
 rtl/rf_wb_sched.sv | 118 +++++++++++
 tb/tb_rf_wb_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_sched_pkg.sv
// Shared sizing constants for the writeback scheduler and its arbiter.
// Latency: none (constants and helpers only).
// Backpressure: not applicable.
package rf_wb_sched_pkg;

    localparam int RF_XLEN  = 32;   // register data width
    localparam int RF_AW    = 5;    // register index width
    localparam int RF_NREGS = 32;   // architectural register count
    localparam int RF_NREQ  = 3;    // default number of writeback requesters

    // Width of a pointer that can name any of n requesters (at least one bit).
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after ptr_i.
// Latency: combinational, zero cycles.
// Backpressure: an ungranted requester simply sees no grant and keeps waiting.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic found;
    int   tgt;

    // Visit requesters ptr+1, ptr+2, ... (wrapping) and grant the first one asking.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        tgt   = 0;
        for (int k = 1; k <= N; k++) begin
            tgt = int'(ptr_i) + k;
            if (tgt >= N) begin
                tgt = tgt - N;
            end
            for (int i = 0; i < N; i++) begin
                if (!found && (i == tgt) && req_i[i]) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file writeback scheduler: hazard scoreboard plus round-robin write port.
// Latency: grant is combinational; the RF write appears one cycle after the transfer.
// Backpressure: issue is stalled on register hazards; requesters wait for req_ready.
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int XLEN = RF_XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic [RF_AW-1:0]         iss_rs1,
    input  logic [RF_AW-1:0]         iss_rs2,
    input  logic [RF_AW-1:0]         iss_rd,
    output logic                     iss_stall,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*RF_AW-1:0]    req_rd,
    input  logic [NREQ*XLEN-1:0]     req_wd,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_wr,
    output logic [RF_AW-1:0]         rf_a3,
    output logic [XLEN-1:0]          rf_wd,
    output logic [RF_NREGS-1:0]      pending,
    output logic                     err
);

    localparam int             PW      = ptr_w(NREQ);
    // Reset to the last requester so that requester 0 is searched first.
    localparam logic [PW-1:0]  PTR_RST = PW'(NREQ - 1);

    logic [RF_NREGS-1:0] pend_q, pend_d;
    logic [PW-1:0]       ptr_q,  ptr_d;
    logic                wr_q,   wr_d;
    logic [RF_AW-1:0]    a3_q,   a3_d;
    logic [XLEN-1:0]     wd_q,   wd_d;
    logic                err_q,  err_d;

    logic                xfer;
    logic [PW-1:0]       g_idx;
    logic [RF_AW-1:0]    g_rd;
    logic [XLEN-1:0]     g_wd;
    logic                issue;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (req_ready)
    );

    // Hazard check against the registered scoreboard only; a bit being cleared
    // this cycle still stalls. pend_q[0] is always 0, so x0 never stalls.
    assign iss_stall = iss_valid & (pend_q[iss_rs1] | pend_q[iss_rs2] | pend_q[iss_rd]);
    assign issue     = iss_valid & ~iss_stall & (iss_rd != '0);

    // Select the granted requester's index, destination and data.
    always_comb begin
        xfer  = |(req_valid & req_ready);
        g_idx = '0;
        g_rd  = '0;
        g_wd  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                g_idx = PW'(i);
                g_rd  = req_rd[i*RF_AW +: RF_AW];
                g_wd  = req_wd[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state: clear on retire, then set on issue so a collision leaves the bit set.
    always_comb begin
        pend_d = pend_q;
        if (xfer) begin
            pend_d[g_rd] = 1'b0;
        end
        if (issue) begin
            pend_d[iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;

        ptr_d = xfer ? g_idx : ptr_q;
        wr_d  = xfer & (g_rd != '0);
        a3_d  = xfer ? g_rd : a3_q;
        wd_d  = xfer ? g_wd : wd_q;
        // A retire to a register nobody is waiting on is a protocol error; the write still goes out.
        err_d = err_q | (xfer & (g_rd != '0) & ~pend_q[g_rd]);
    end

    // State registers; reset drops the scoreboard and any staged write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            ptr_q  <= PTR_RST;
            wr_q   <= 1'b0;
            a3_q   <= '0;
            wd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            wr_q   <= wr_d;
            a3_q   <= a3_d;
            wd_q   <= wd_d;
            err_q  <= err_d;
        end
    end

    assign pending = pend_q;
    assign rf_wr   = wr_q;
    assign rf_a3   = a3_q;
    assign rf_wd   = wd_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed scenarios then randomized traffic vs a reference model.
// Latency: registered outputs checked 1 time unit after each rising edge.
// Backpressure: requests follow the reference model's round-robin choice.
module tb_rf_wb_sched;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                  clk;
    logic                  rst;
    logic                  iss_valid;
    logic [4:0]            iss_rs1, iss_rs2, iss_rd;
    logic                  iss_stall;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*5-1:0]     req_rd;
    logic [NREQ*XLEN-1:0]  req_wd;
    logic [NREQ-1:0]       req_ready;
    logic                  rf_wr;
    logic [4:0]            rf_a3;
    logic [XLEN-1:0]       rf_wd;
    logic [31:0]           pending;
    logic                  err;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pend;
    int          m_ptr;
    logic        m_wr;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic        m_err;

    rf_wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_wd    (req_wd),
        .req_ready (req_ready),
        .rf_wr     (rf_wr),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd),
        .pending   (pending),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_ptr  = NREQ - 1;
        m_wr   = 1'b0;
        m_a3   = '0;
        m_wd   = '0;
        m_err  = 1'b0;
    endtask

    function automatic bit busy(input logic [4:0] r);
        return (r != 0) && m_pend[r];
    endfunction

    function automatic bit m_stall();
        return iss_valid && (busy(iss_rs1) || busy(iss_rs2) || busy(iss_rd));
    endfunction

    // First valid requester after the last winner, wrapping around.
    function automatic int m_grant();
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        iss_valid = v;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
        iss_rd    = rd;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] wd);
        req_valid[i]        = v;
        req_rd[i*5 +: 5]    = rd;
        req_wd[i*32 +: 32]  = wd;
    endtask

    task automatic clr_req();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 32'd0);
    endtask

    // One clock: check combinational outputs, clock, advance model, check registered outputs.
    // Called just after a falling edge with inputs already driven; returns on the next falling edge.
    task automatic cyc();
        bit              st;
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic [4:0]      rd;
        logic [31:0]     np;
        #1;
        st = m_stall();
        g  = m_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("iss_stall", iss_stall, st);
        chk("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        if (rst) begin
            np = m_pend;
            if (g >= 0) begin
                rd = req_rd[g*5 +: 5];
                if (rd != 0 && !m_pend[rd]) m_err = 1'b1;
                m_wr  = (rd != 0);
                m_a3  = rd;
                m_wd  = req_wd[g*32 +: 32];
                m_ptr = g;
                np[rd] = 1'b0;
            end else begin
                m_wr = 1'b0;
            end
            if (iss_valid && !st && iss_rd != 0) np[iss_rd] = 1'b1;
            m_pend = np;
        end
        #1;
        chk("pending", pending, m_pend);
        chk("rf_wr", rf_wr, m_wr);
        chk("rf_a3", rf_a3, m_a3);
        chk("rf_wd", rf_wd, m_wd);
        chk("err", err, m_err);
        @(negedge clk);
    endtask

    // Destination for a random request: usually an outstanding register, sometimes anything.
    function automatic logic [4:0] pick_rd();
        logic [4:0] r;
        if ($urandom_range(0, 3) != 0) begin
            for (int t = 0; t < 32; t++) begin
                r = 5'($urandom_range(0, 15));
                if (m_pend[r]) return r;
            end
        end
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b0;
        model_reset();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        req_valid = '0;
        req_rd    = '0;
        req_wd    = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pending", pending, 32'd0);
        chk("rst_rf_wr", rf_wr, 1'b0);
        chk("rst_rf_a3", rf_a3, 5'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", req_ready, 3'b000);
        @(negedge clk);
        rst = 1'b1;

        // three registers outstanding, then all requesters stream for six cycles
        for (int r = 1; r <= 3; r++) begin
            set_iss(1'b1, 5'd0, 5'd0, 5'(r));
            cyc();
        end
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h1000 + 32'(i));
        for (int c = 0; c < 6; c++) begin
            logic [NREQ-1:0] want;
            want = '0;
            want[c % NREQ] = 1'b1;
            #1;
            chk("rr_order", req_ready, want);
            cyc();
            chk("rr_nobubble", rf_wr, 1'b1);
        end
        clr_req();

        // reset mid-operation with x8..x11 outstanding and a grant on offer
        for (int r = 8; r <= 11; r++) begin
            set_iss(1'b1, 5'd0, 5'd0, 5'(r));
            cyc();
        end
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        chk("pre_rst_pend", pending, 32'h0000_0F00);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(8 + i), 32'hA0 + 32'(i));
        #1;
        chk("midrst_pend", pending, 32'd0);
        chk("midrst_wr", rf_wr, 1'b0);
        chk("midrst_err", err, 1'b0);
        chk("midrst_ready", req_ready, 3'b001);
        cyc();
        rst = 1'b1;
        clr_req();
        cyc();
        chk("postrst_nowr", rf_wr, 1'b0);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'd0, 32'hB0 + 32'(i));
        #1;
        chk("postrst_first", req_ready, 3'b001);
        cyc();
        clr_req();

        // write to x0 from requester 1
        set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
        cyc();
        chk("x0_wr", rf_wr, 1'b0);
        chk("x0_err", err, 1'b0);
        chk("x0_pend", pending, 32'd0);
        clr_req();

        // issue x9 while requester 0 retires x4
        set_iss(1'b1, 5'd0, 5'd0, 5'd4);
        cyc();
        set_iss(1'b1, 5'd0, 5'd0, 5'd9);
        set_req(0, 1'b1, 5'd4, 32'h44);
        cyc();
        chk("same_cyc_p9", pending[9], 1'b1);
        chk("same_cyc_p4", pending[4], 1'b0);
        clr_req();

        // read-after-write hazard on x5
        set_iss(1'b1, 5'd0, 5'd0, 5'd5);
        cyc();
        set_iss(1'b1, 5'd5, 5'd0, 5'd0);
        #1;
        chk("raw_stall", iss_stall, 1'b1);
        cyc();
        set_req(0, 1'b1, 5'd5, 32'h55);
        #1;
        chk("raw_nobypass", iss_stall, 1'b1);
        cyc();
        chk("raw_wr", rf_wr, 1'b1);
        chk("raw_a3", rf_a3, 5'd5);
        clr_req();
        #1;
        chk("raw_release", iss_stall, 1'b0);
        cyc();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);

        // retire to a register that is not outstanding
        set_req(2, 1'b1, 5'd7, 32'h7777_7777);
        cyc();
        chk("spur_err", err, 1'b1);
        chk("spur_wr", rf_wr, 1'b1);
        chk("spur_a3", rf_a3, 5'd7);
        chk("spur_wd", rf_wd, 32'h7777_7777);
        clr_req();
        cyc();
        chk("spur_sticky", err, 1'b1);

        // fresh start, then random traffic
        rst = 1'b0;
        model_reset();
        cyc();
        rst = 1'b1;
        for (int n = 0; n < 400; n++) begin
            set_iss(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 11)));
            for (int i = 0; i < NREQ; i++)
                set_req(i, ($urandom_range(0, 2) != 0), pick_rd(), $urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
